// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: register-file geometry and base opcodes.
// Decode, scoreboard and the execute stages all use these definitions.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/reg_scoreboard_sat_counter.sv
// Saturating up-counter: adds one per enabled cycle and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per architectural register and
// holds decode on RAW/WAW hazards, counting the stalled cycles.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_src1,
    input  logic [4:0]       issue_src2,
    input  logic [4:0]       issue_dest,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_cnt
);

    // x0 never has a pending write, so only bits 31:1 are stored.
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;
    logic [NUM_REGS-1:0] eb;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                hazard;
    logic                fire;
    logic                stall_inc;

    always_comb begin
        eb = {busy_q, 1'b0};
        if (WB_BYPASS && wb_valid) begin
            eb[wb_rd] = 1'b0;
        end

        hazard      = eb[issue_src1] | eb[issue_src2] | eb[issue_dest];
        issue_ready = ~hazard & ~flush;
        fire        = issue_valid & issue_ready;
        stall_inc   = issue_valid & ~issue_ready & ~flush;

        // Clear first, then set, so a same-cycle set on wb_rd wins.
        busy_nxt = {busy_q, 1'b0};
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (fire) begin
            busy_nxt[issue_dest] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_d = busy_nxt[NUM_REGS-1:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = {busy_q, 1'b0};

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios followed by random
// traffic, all compared against a set-of-pending-registers reference model.
module tb_reg_scoreboard;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic [4:0]       issue_src1 = '0;
    logic [4:0]       issue_src2 = '0;
    logic [4:0]       issue_dest = '0;
    logic             issue_ready;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic             flush = 1'b0;
    logic [31:0]      busy_vec;
    logic [CNT_W-1:0] stall_cnt;

    reg_scoreboard #(
        .WB_BYPASS (1'b1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_src1  (issue_src1),
        .issue_src2  (issue_src2),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .busy_vec    (busy_vec),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: which registers have a write in flight, and stall total.
    bit pending [32];
    int m_stall;

    logic        s_ready;
    logic [31:0] s_busy;
    logic [31:0] s_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit blocks(input int r, input bit wv, input int wr);
        // A register blocks issue if a write is in flight and not retiring now.
        if (r == 0) return 1'b0;
        if (wv && wr == r) return 1'b0;
        return pending[r];
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = pending[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pending[i] = 1'b0;
        m_stall = 0;
    endtask

    task automatic step(input bit r, input bit v, input int s1, input int s2, input int d,
                        input bit wv, input int wr, input bit fl);
        bit exp_ready;
        @(negedge clk);
        rst         = r;
        issue_valid = v;
        issue_src1  = 5'(s1);
        issue_src2  = 5'(s2);
        issue_dest  = 5'(d);
        wb_valid    = wv;
        wb_rd       = 5'(wr);
        flush       = fl;
        #1;
        exp_ready = !fl && !blocks(s1, wv, wr) && !blocks(s2, wv, wr) && !blocks(d, wv, wr);
        s_ready = issue_ready;
        s_busy  = busy_vec;
        s_cnt   = 32'(stall_cnt);
        check_val("issue_ready", 32'(s_ready), 32'(exp_ready));
        check_val("busy_vec", s_busy, model_vec());
        check_val("stall_cnt", s_cnt, 32'(m_stall));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (v && !exp_ready && !fl && m_stall < CNT_MAX) m_stall++;
            if (fl) begin
                for (int i = 0; i < 32; i++) pending[i] = 1'b0;
            end else begin
                if (wv && wr != 0) pending[wr] = 1'b0;
                if (v && exp_ready && d != 0) pending[d] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);

        // Empty scoreboard after reset: everything may issue.
        step(0, 1, 17, 30, 9, 0, 0, 0);
        check_val("reset_ready", 32'(s_ready), 32'd1);
        check_val("reset_busy", s_busy, 32'd0);
        check_val("reset_cnt", s_cnt, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // RAW on x5, released by same-cycle writeback.
        step(0, 1, 0, 0, 5, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0);
        check_val("raw_stall", 32'(s_ready), 32'd0);
        step(0, 1, 5, 0, 0, 1, 5, 0);
        check_val("raw_cnt", s_cnt, 32'd1);
        check_val("raw_bypass", 32'(s_ready), 32'd1);

        // WAW on x7.
        step(0, 1, 0, 0, 7, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 7, 0, 0, 0);
        check_val("waw_stall", 32'(s_ready), 32'd0);
        step(0, 1, 0, 0, 7, 1, 7, 0);
        check_val("waw_release", 32'(s_ready), 32'd1);
        idle();
        check_val("waw_rebusy", 32'(s_busy[7]), 32'd1);
        step(0, 0, 0, 0, 0, 1, 7, 0);

        // x0 never becomes pending.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check_val("x0_ready", 32'(s_ready), 32'd1);
        check_val("x0_busy", 32'(s_busy[0]), 32'd0);

        // Set beats clear on x3.
        step(0, 1, 0, 0, 3, 0, 0, 0);
        step(0, 1, 0, 0, 3, 1, 3, 0);
        idle();
        check_val("setclr_busy3", 32'(s_busy[3]), 32'd1);

        // Flush then reset.
        foreach (pending[i]) if (i == 1 || i == 2 || i == 8 || i == 9 || i == 10 || i == 11)
            step(0, 1, 0, 0, i, 0, 0, 0);
        idle();
        check_val("pre_flush", s_busy, 32'h0000_0F0E);
        step(0, 1, 0, 0, 20, 0, 0, 1);
        idle();
        check_val("post_flush", s_busy, 32'd0);
        step(0, 1, 0, 0, 12, 0, 0, 0);
        step(0, 1, 12, 0, 0, 0, 0, 0);
        step(1, 1, 12, 0, 0, 0, 0, 0);
        step(0, 1, 12, 0, 0, 0, 0, 0);
        check_val("post_rst_busy", s_busy, 32'd0);
        check_val("post_rst_cnt", s_cnt, 32'd0);
        check_val("post_rst_ready", 32'(s_ready), 32'd1);

        // Saturation: 20 stalled cycles on a 4-bit counter.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 4, 0, 0, 0);
        repeat (20) step(0, 1, 4, 0, 0, 0, 0, 0);
        idle();
        check_val("sat_cnt", s_cnt, 32'd15);
        idle();
        check_val("sat_hold", s_cnt, 32'd15);

        // Random traffic on a narrow register window to provoke hazards.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(99) < 2), $urandom_range(1),
                 $urandom_range(7), $urandom_range(7), $urandom_range(7),
                 ($urandom_range(99) < 35), $urandom_range(7),
                 ($urandom_range(99) < 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
